// File: rtl/psychic5_rom_arbiter.sv
// Purpose: shares one external ROM/SDRAM read port among tile, sprite, main-CPU and sound-CPU requesters.
// Latency: request sampled in IDLE, read strobe next cycle, ACK one cycle after i_MEM_RDY (>= 3 cycles per access).
// Backpressure: requesters hold i_REQ/address until their ACK; BUSY waits on i_MEM_RDY, aborting after TMO cycles.
// Build option: define PSYCHIC5_ARB_RR_EN for rotating priority; default is strict priority (bit0 highest).
module psychic5_rom_arbiter #(
  parameter int AW  = 22,
  parameter int DW  = 16,
  parameter int TMO = 255
) (
  input  logic            i_EMU_MCLK,
  input  logic            i_EMU_MRST_n,
  input  logic [3:0]      i_REQ,
  input  logic [4*AW-1:0] i_ADDR,
  output logic [3:0]      o_ACK,
  output logic [DW-1:0]   o_DATA,
  output logic            o_ERR,
  output logic            o_MEM_RD,
  output logic [AW-1:0]   o_MEM_ADDR,
  input  logic            i_MEM_RDY,
  input  logic [DW-1:0]   i_MEM_DATA
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t     state;
  state_t     state_nxt;
  logic [1:0] grant;
  logic [1:0] win;
  logic [7:0] cnt;
  logic       tmo_hit;

`ifdef PSYCHIC5_ARB_RR_EN
  logic [1:0] ptr;
  logic [3:0] rot;
  logic [1:0] ofs;

  // Rotating priority: rotate requests so the pointer position is bit0, pick the lowest set bit, rotate back.
  always_comb begin
    case (ptr)
      2'd0:    rot = i_REQ;
      2'd1:    rot = {i_REQ[0], i_REQ[3:1]};
      2'd2:    rot = {i_REQ[1:0], i_REQ[3:2]};
      default: rot = {i_REQ[2:0], i_REQ[3]};
    endcase
    ofs = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (rot[i]) ofs = 2'(i);
    end
    win = ptr + ofs;
  end

  // Pointer moves to the requester after the one being acknowledged, as DONE is entered.
  always_ff @(posedge i_EMU_MCLK or negedge i_EMU_MRST_n) begin
    if (!i_EMU_MRST_n) begin
      ptr <= 2'd0;
    end else if (state == BUSY && state_nxt == DONE) begin
      ptr <= grant + 2'd1;
    end
  end
`else
  // Strict priority: lowest-numbered active request wins, so video fetches always go first.
  always_comb begin
    win = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (i_REQ[i]) win = 2'(i);
    end
  end
`endif

  // The wait that would bring the counter to TMO is the last one allowed.
  assign tmo_hit = (({1'b0, cnt} + 9'd1) == 9'(TMO));

  // State register.
  always_ff @(posedge i_EMU_MCLK or negedge i_EMU_MRST_n) begin
    if (!i_EMU_MRST_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; a memory response wins over a simultaneous timeout.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (|i_REQ) state_nxt = BUSY;
      BUSY:    if (i_MEM_RDY || tmo_hit) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Registered outputs and access context: grant/address latch, wait counter, data capture, ACK/ERR pulses.
  always_ff @(posedge i_EMU_MCLK or negedge i_EMU_MRST_n) begin
    if (!i_EMU_MRST_n) begin
      grant      <= 2'd0;
      cnt        <= 8'd0;
      o_ACK      <= 4'd0;
      o_DATA     <= '0;
      o_ERR      <= 1'b0;
      o_MEM_RD   <= 1'b0;
      o_MEM_ADDR <= '0;
    end else begin
      o_MEM_RD <= (state_nxt == BUSY);
      o_ACK    <= 4'd0;
      o_ERR    <= 1'b0;
      case (state)
        IDLE: begin
          if (|i_REQ) begin
            grant      <= win;
            o_MEM_ADDR <= i_ADDR[int'(win)*AW +: AW];
            cnt        <= 8'd0;
          end
        end
        BUSY: begin
          if (i_MEM_RDY) begin
            o_DATA <= i_MEM_DATA;
            o_ACK  <= 4'd1 << grant;
          end else if (tmo_hit) begin
            o_DATA <= '1;
            o_ERR  <= 1'b1;
            o_ACK  <= 4'd1 << grant;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
